// File: rtl/axis_packet_arbiter.sv
// Round-robin packet arbiter: merges NUM_INPUTS AXI4-Stream sources onto one output,
// locking onto a source for a whole packet and arbitrating in one idle cycle between packets.
module axis_packet_arbiter #(
  parameter  int NUM_INPUTS = 4,
  parameter  int AXI_WIDTH  = 512,
  localparam int KW         = AXI_WIDTH / 8,
  localparam int GW         = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_INPUTS-1:0]                in_tvalid_i,
  input  logic [NUM_INPUTS-1:0][AXI_WIDTH-1:0] in_tdata_i,
  input  logic [NUM_INPUTS-1:0][KW-1:0]        in_tkeep_i,
  input  logic [NUM_INPUTS-1:0]                in_tlast_i,
  output logic [NUM_INPUTS-1:0]                in_tready_o,
  output logic                                 out_tvalid_o,
  output logic [AXI_WIDTH-1:0]                 out_tdata_o,
  output logic [KW-1:0]                        out_tkeep_o,
  output logic                                 out_tlast_o,
  input  logic                                 out_tready_i,
  input  logic [NUM_INPUTS-1:0]                enable_i,
  output logic [GW-1:0]                        grant_id_o,
  output logic                                 busy_o
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [GW-1:0]           grant_q, grant_d;
  logic [GW-1:0]           last_grant_q, last_grant_d;
  logic                    locked;
  logic                    end_of_pkt;
  logic [NUM_INPUTS-1:0]   cand;
  logic                    pick_found;
  logic [GW-1:0]           pick_idx;
  logic [GW-1:0]           sel;
  int                      idx;

  // Outputs are gated by rst_n so a reset abandons an in-flight packet in the same cycle.
  assign locked     = rst_n && (state_q == LOCKED);
  assign cand       = in_tvalid_i & enable_i;
  assign end_of_pkt = out_tvalid_o && out_tready_i && out_tlast_o;
  assign busy_o     = locked;
  assign grant_id_o = rst_n ? grant_q : '0;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    idx        = 0;
    sel        = '0;
    for (int k = 1; k <= NUM_INPUTS; k++) begin
      idx = int'(last_grant_q) + k;
      if (idx >= NUM_INPUTS) idx = idx - NUM_INPUTS;
      sel = GW'(idx);
      if (!pick_found && cand[sel]) begin
        pick_found = 1'b1;
        pick_idx   = sel;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (end_of_pkt) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The locked source is muxed straight through, so data beats see no added latency.
  always_comb begin
    out_tvalid_o = 1'b0;
    out_tdata_o  = '0;
    out_tkeep_o  = '0;
    out_tlast_o  = 1'b0;
    in_tready_o  = '0;
    if (locked) begin
      out_tvalid_o         = in_tvalid_i[grant_q];
      out_tdata_o          = in_tdata_i[grant_q];
      out_tkeep_o          = in_tkeep_i[grant_q];
      out_tlast_o          = in_tlast_i[grant_q];
      in_tready_o[grant_q] = out_tready_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_INPUTS - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n) $onehot0(in_tready_o));
  assert property (@(posedge clk) disable iff (!rst_n) int'(grant_q) < NUM_INPUTS);

endmodule

// File: doc/axis_packet_arbiter.md
AXIS_PACKET_ARBITER -- requirements
Module: axis_packet_arbiter

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 4, number of requesting AXI4S streams (1..16).
REQ-002 SHALL have parameter AXI_WIDTH, default 512, tdata width of all streams, multiple of 8.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port in[NUM_INPUTS]  AXI4S.s array  AXI_WIDTH  requesting packet streams.
REQ-006 SHALL have port out  AXI4S.m  AXI_WIDTH  shared output stream.
REQ-007 SHALL have port enable  input  NUM_INPUTS  per-input request mask; bit i=0 excludes in[i] from new grants.
REQ-008 SHALL have port grant_id  output  max(1,$clog2(NUM_INPUTS))  index of the currently or most recently granted input.
REQ-009 SHALL have port busy  output  1  high while a packet is locked (LOCKED state).

Function
REQ-010 SHALL implement a two-state FSM: IDLE and LOCKED.
REQ-011 In IDLE, SHALL drive out.tvalid=0 and all in[i].tready=0.
REQ-012 In IDLE, SHALL compute the candidate set as in[i].tvalid && enable[i].
REQ-013 In IDLE with a non-empty candidate set, SHALL pick the first candidate searching (last_grant+1) mod NUM_INPUTS upward with wrap-around, register it into grant_id, and enter LOCKED at the next edge.
REQ-014 In IDLE with an empty candidate set, SHALL remain in IDLE with grant_id unchanged.
REQ-015 In LOCKED, SHALL drive out.tdata/tkeep/tlast/tvalid combinationally from in[grant_id].
REQ-016 In LOCKED, SHALL drive in[grant_id].tready = out.tready and in[j].tready = 0 for every j != grant_id.
REQ-017 In LOCKED, SHALL return to IDLE at the edge where out.tvalid && out.tready && out.tlast, updating last_grant to grant_id.
REQ-018 SHALL add no latency to data beats in LOCKED.
REQ-019 SHALL insert exactly one idle cycle (arbitration) between consecutive packets.
REQ-020 SHALL ignore changes to enable during LOCKED; the locked packet completes regardless.
REQ-021 SHALL neither drop nor duplicate beats; tkeep passes through unmodified, including partial last beats.
REQ-022 SHALL let a source deassert tvalid mid-packet; the FSM stays LOCKED with out.tvalid=0 meanwhile.
REQ-023 With NUM_INPUTS=1, SHALL behave as a pass-through with one idle cycle between packets; grant_id stays 0.
REQ-024 A single-beat packet (tlast on its first beat) SHALL occupy exactly one LOCKED cycle when out.tready=1.

Reset
REQ-025 While rst_n=0, SHALL force state=IDLE, grant_id=0, last_grant=NUM_INPUTS-1, busy=0, out.tvalid=0, all in[i].tready=0.
REQ-026 Reset asserted mid-packet SHALL abandon the packet immediately; the first grant after reset SHALL go to the lowest-index candidate.

Verification
REQ-027 Reset, then in[0] and in[2] both valid with 3-beat packets, enable=4'b1111, out.tready=1 -> in[0] granted first (grant_id=0), 3 beats out, 1 idle cycle, then in[2] (grant_id=2).
REQ-028 All four inputs continuously valid with 2-beat packets -> grant order 0,1,2,3,0,1; each packet contiguous on out; busy low exactly one cycle between packets.
REQ-029 in[1] locked on a 4-beat packet, out.tready toggled 1,0,1,0,1,1, enable[1] cleared after beat 1 -> all 4 beats delivered in order with no duplicates; in[1].tready mirrors out.tready; in[3].tready stays 0.
REQ-030 enable=4'b0101, in[1] and in[3] valid, in[0] and in[2] idle -> no grant, out.tvalid=0, busy=0; setting enable[3]=1 -> grant_id=3 one edge later.
REQ-031 rst_n pulsed low for one cycle during beat 2 of a 5-beat packet from in[3] -> out.tvalid=0 and busy=0 in the reset cycle; the next grant goes to the lowest-index valid, enabled input.
REQ-032 Last beat tkeep=64'h0000_0000_0000_FFFF with AXI_WIDTH=512 -> out.tkeep identical on that beat, out.tlast=1, FSM in IDLE next cycle.
